// File: rtl/morse_keyer_pkg.sv
// Shared types and constants for the iambic paddle keyer.
// State encoding, element length ratios and timer width live here.
package morse_keyer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIT  = 2'd1,
    DAH  = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int DAH_RATIO = 3;
  localparam int GAP_RATIO = 1;
  localparam int TIMER_W   = 10;

  // A dot length of 0 ms would never end an element, so it reads as 1 ms.
  function automatic logic [TIMER_W-1:0] norm_dot(input logic [7:0] ms);
    return (ms == 8'd0) ? TIMER_W'(1) : TIMER_W'(ms);
  endfunction

endpackage

// File: rtl/iambic_keyer_paddle_sync.sv
// Paddle input conditioning: SYNC_STAGES-deep synchronizer followed by
// polarity normalization, so pressed is 1 whenever the paddle is held.
module paddle_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pressed
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Reset to the released level so no phantom press appears after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    else     sync_q <= sync_d;
  end

  assign pressed = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

endmodule

// File: rtl/iambic_keyer.sv
// Iambic paddle keyer: turns dit/dah paddles into a timed key waveform.
// Define IAMBIC_MODE_B_EN for mode B (element memories); default is mode A.
module iambic_keyer
  import morse_keyer_pkg::*;
#(
  parameter bit PADDLE_ACTIVE_LOW = 1'b1,
  parameter int SYNC_STAGES       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ms_tick,
  input  logic       paddle_dit,
  input  logic       paddle_dah,
  input  logic [7:0] dot_ms,
  output logic       key_out,
  output logic       busy,
  output logic       elem_start,
  output logic       elem_is_dah
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [TIMER_W-1:0] DAH_MUL = TIMER_W'(DAH_RATIO);
  localparam logic [TIMER_W-1:0] GAP_MUL = TIMER_W'(GAP_RATIO);

  logic dit_p, dah_p;

  paddle_sync #(.SYNC_STAGES(SYNC_N), .ACTIVE_LOW(PADDLE_ACTIVE_LOW)) u_dit_sync (
    .clk(clk), .rst(rst), .raw(paddle_dit), .pressed(dit_p)
  );

  paddle_sync #(.SYNC_STAGES(SYNC_N), .ACTIVE_LOW(PADDLE_ACTIVE_LOW)) u_dah_sync (
    .clk(clk), .rst(rst), .raw(paddle_dah), .pressed(dah_p)
  );

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   cnt_q, cnt_d;
  logic [TIMER_W-1:0]   dot_len_q, dot_len_d;
  logic                 entry_q, entry_d;
  logic                 last_dah_q, last_dah_d;
  logic                 key_q, key_d;
  logic                 busy_q, busy_d;
  logic                 start_q, start_d;
  logic                 is_dah_q, is_dah_d;
  logic [TIMER_W-1:0]   cur_len;
  logic                 done, start_dit, start_dah, dit_req, dah_req;
  logic                 dit_mem_q, dah_mem_q;

`ifdef IAMBIC_MODE_B_EN
  logic dit_mem_d, dah_mem_d;

  // A memory is armed by the opposite paddle and consumed by the element it asks for.
  always_comb begin
    dit_mem_d = dit_mem_q;
    dah_mem_d = dah_mem_q;
    if (dit_p && (state_q == DAH || (state_q == GAP && last_dah_q))) dit_mem_d = 1'b1;
    if (dah_p && (state_q == DIT || (state_q == GAP && !last_dah_q))) dah_mem_d = 1'b1;
    if (start_dit || state_d == IDLE) dit_mem_d = 1'b0;
    if (start_dah || state_d == IDLE) dah_mem_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dit_mem_q <= 1'b0;
      dah_mem_q <= 1'b0;
    end else begin
      dit_mem_q <= dit_mem_d;
      dah_mem_q <= dah_mem_d;
    end
  end
`else
  assign dit_mem_q = 1'b0;
  assign dah_mem_q = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dot_len_d  = dot_len_q;
    last_dah_d = last_dah_q;
    start_dit  = 1'b0;
    start_dah  = 1'b0;
    dit_req    = dit_p | dit_mem_q;
    dah_req    = dah_p | dah_mem_q;

    case (state_q)
      DIT:     cur_len = dot_len_q;
      DAH:     cur_len = DAH_MUL * dot_len_q;
      GAP:     cur_len = GAP_MUL * dot_len_q;
      default: cur_len = '0;
    endcase

    // The entry cycle never counts a tick, giving an element length in (len-1, len] ms.
    cnt_d = cnt_q + TIMER_W'(ms_tick && !entry_q);
    done  = (state_q != IDLE) && (cnt_d == cur_len);

    case (state_q)
      IDLE: begin
        if (dit_p)      start_dit = 1'b1;
        else if (dah_p) start_dah = 1'b1;
      end
      DIT: if (done) begin
        state_d    = GAP;
        last_dah_d = 1'b0;
      end
      DAH: if (done) begin
        state_d    = GAP;
        last_dah_d = 1'b1;
      end
      GAP: if (done) begin
        if (!last_dah_q) begin
          if (dah_req)    start_dah = 1'b1;
          else if (dit_p) start_dit = 1'b1;
          else            state_d   = IDLE;
        end else begin
          if (dit_req)    start_dit = 1'b1;
          else if (dah_p) start_dah = 1'b1;
          else            state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_dit) state_d = DIT;
    if (start_dah) state_d = DAH;
    if (start_dit || start_dah) dot_len_d = norm_dot(dot_ms);

    entry_d = (state_d != state_q);
    if (entry_d || state_q == IDLE) cnt_d = '0;

    key_d    = (state_d == DIT) || (state_d == DAH);
    busy_d   = (state_d != IDLE);
    start_d  = start_dit | start_dah;
    is_dah_d = start_dah ? 1'b1 : (start_dit ? 1'b0 : is_dah_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dot_len_q  <= TIMER_W'(1);
      entry_q    <= 1'b0;
      last_dah_q <= 1'b0;
      key_q      <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      is_dah_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dot_len_q  <= dot_len_d;
      entry_q    <= entry_d;
      last_dah_q <= last_dah_d;
      key_q      <= key_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      is_dah_q   <= is_dah_d;
    end
  end

  assign key_out     = key_q;
  assign busy        = busy_q;
  assign elem_start  = start_q;
  assign elem_is_dah = is_dah_q;

endmodule

// File: tb/tb_iambic_keyer.sv
// Bench for iambic_keyer: directed paddle scenarios plus random paddle traffic,
// compared cycle by cycle against a countdown-based keyer model.
module tb_iambic_keyer;

  localparam int T    = 16;  // clock cycles per ms_tick
  localparam int SYNC = 2;

  localparam int P_IDLE = 0;
  localparam int P_DIT  = 1;
  localparam int P_DAH  = 2;
  localparam int P_GAP  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ms_tick = 1'b0;
  logic       paddle_dit = 1'b1;
  logic       paddle_dah = 1'b1;
  logic [7:0] dot_ms = 8'd5;
  logic       key_out, busy, elem_start, elem_is_dah;

  iambic_keyer dut (
    .clk(clk), .rst(rst), .ms_tick(ms_tick),
    .paddle_dit(paddle_dit), .paddle_dah(paddle_dah), .dot_ms(dot_ms),
    .key_out(key_out), .busy(busy), .elem_start(elem_start), .elem_is_dah(elem_is_dah)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  bit dit_on = 1'b0, dah_on = 1'b0;
  bit dit_line[$], dah_line[$];
  int m_phase, m_left, m_dot;
  bit m_fresh, m_last_dah, m_dit_mem, m_dah_mem;
  bit m_key, m_busy, m_start, m_is_dah;
  int cyc = 0;

  // Scoreboard
  logic [10:0] exp_q[$];
  bit          seen[$];
  int          dur_q[$];
  int          hi_cnt = 0;
  int          cur_len = 1;

  task automatic model_reset();
    dit_line.delete();
    dah_line.delete();
    repeat (SYNC) begin
      dit_line.push_back(1'b0);
      dah_line.push_back(1'b0);
    end
    m_phase = P_IDLE; m_left = 0; m_dot = 1; m_fresh = 1'b0; m_last_dah = 1'b0;
    m_dit_mem = 1'b0; m_dah_mem = 1'b0;
    m_key = 1'b0; m_busy = 1'b0; m_start = 1'b0; m_is_dah = 1'b0;
  endtask

  task automatic begin_elem(input bit is_dah, input int dot);
    m_phase  = is_dah ? P_DAH : P_DIT;
    m_dot    = dot;
    m_left   = is_dah ? 3 * dot : dot;
    m_fresh  = 1'b1;
    m_start  = 1'b1;
    m_is_dah = is_dah;
    if (is_dah) m_dah_mem = 1'b0;
    else        m_dit_mem = 1'b0;
    exp_q.push_back({is_dah, 10'(m_left)});
  endtask

  task automatic model_edge(input bit d, input bit a, input bit tk);
    bit dp, ap, ended;
    int dot;
    dp = dit_line.pop_front(); dit_line.push_back(d);
    ap = dah_line.pop_front(); dah_line.push_back(a);
    m_start = 1'b0;
    ended   = 1'b0;
    dot     = (dot_ms == 8'd0) ? 1 : int'(dot_ms);
    if (m_phase != P_IDLE) begin
      if (!m_fresh && tk) m_left--;
      m_fresh = 1'b0;
      ended   = (m_left == 0);
    end
`ifdef IAMBIC_MODE_B_EN
    if (ap && (m_phase == P_DIT || (m_phase == P_GAP && !m_last_dah))) m_dah_mem = 1'b1;
    if (dp && (m_phase == P_DAH || (m_phase == P_GAP && m_last_dah))) m_dit_mem = 1'b1;
`endif
    if (m_phase == P_IDLE) begin
      if (dp)      begin_elem(1'b0, dot);
      else if (ap) begin_elem(1'b1, dot);
    end else if (ended && m_phase != P_GAP) begin
      m_last_dah = (m_phase == P_DAH);
      m_phase = P_GAP; m_left = m_dot; m_fresh = 1'b1;
    end else if (ended) begin
      if (!m_last_dah && (ap || m_dah_mem))     begin_elem(1'b1, dot);
      else if (!m_last_dah && dp)               begin_elem(1'b0, dot);
      else if (m_last_dah && (dp || m_dit_mem)) begin_elem(1'b0, dot);
      else if (m_last_dah && ap)                begin_elem(1'b1, dot);
      else begin
        m_phase = P_IDLE; m_dit_mem = 1'b0; m_dah_mem = 1'b0;
      end
    end
    m_key  = (m_phase == P_DIT) || (m_phase == P_DAH);
    m_busy = (m_phase != P_IDLE);
  endtask

  task automatic set_paddles(input bit d, input bit a);
    dit_on = d; dah_on = a;
    paddle_dit = ~d; paddle_dah = ~a;
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic tick_cycle();
    logic [10:0] e;
    int lo, hi;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(dit_on, dah_on, ms_tick);
    @(negedge clk);
    check("outs", {28'd0, key_out, busy, elem_start, elem_is_dah},
          {28'd0, m_key, m_busy, m_start, m_is_dah});
    if (rst) begin
      exp_q.delete();
      hi_cnt = 0;
    end else begin
      if (elem_start) begin
        check("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("elem_type", elem_is_dah, e[10]);
          cur_len = int'(e[9:0]);
          seen.push_back(elem_is_dah);
        end
      end
      if (key_out) hi_cnt++;
      else if (hi_cnt > 0) begin
        lo = (cur_len - 1) * T + 2;
        hi = cur_len * T + 1;
        check("elem_len", (hi_cnt >= lo) && (hi_cnt <= hi), 1);
        dur_q.push_back(hi_cnt);
        hi_cnt = 0;
      end
    end
    cyc++;
    ms_tick = ((cyc % T) == T - 1);
  endtask

  task automatic wait_ms(input int n);
    repeat (n * T) tick_cycle();
  endtask

  task automatic scen_start(input int dot);
    dot_ms = 8'(dot);
    seen.delete();
    dur_q.delete();
  endtask

  initial begin
    model_reset();
    set_paddles(1'b0, 1'b0);
    rst = 1'b1;
    repeat (4) tick_cycle();
    rst = 1'b0;
    wait_ms(2);

    // Single dit tap
    scen_start(5);
    set_paddles(1'b1, 1'b0);
    wait_ms(2);
    set_paddles(1'b0, 1'b0);
    wait_ms(20);
    check("s1_count", seen.size(), 1);
    if (seen.size() > 0) check("s1_type", seen[0], 0);

    // Dah held through the first gap
    scen_start(5);
    set_paddles(1'b0, 1'b1);
    wait_ms(22);
    set_paddles(1'b0, 1'b0);
    wait_ms(40);
    check("s2_count", seen.size(), 2);
    if (seen.size() == 2) begin
      check("s2_first", seen[0], 1);
      check("s2_second", seen[1], 1);
    end

    // Squeeze
    scen_start(4);
    set_paddles(1'b1, 1'b1);
    wait_ms(60);
    set_paddles(1'b0, 1'b0);
    wait_ms(40);
    check("s3_count", seen.size() >= 4, 1);
    if (seen.size() >= 4) begin
      check("s3_first_dit", seen[0], 0);
      for (int i = 1; i < 4; i++) check("s3_alternate", seen[i], !seen[i-1]);
    end

    // Brief dah press during a held dit
    scen_start(5);
    set_paddles(1'b1, 1'b0);
    wait_ms(2);
    set_paddles(1'b1, 1'b1);
    wait_ms(1);
    set_paddles(1'b1, 1'b0);
    wait_ms(37);
    set_paddles(1'b0, 1'b0);
    wait_ms(40);
    check("s4_count", seen.size() >= 3, 1);
    if (seen.size() >= 3) begin
      check("s4_first", seen[0], 0);
`ifdef IAMBIC_MODE_B_EN
      check("s4_mem_dah", seen[1], 1);
      check("s4_resume", seen[2], 0);
`else
      check("s4_no_dah", seen[1], 0);
      check("s4_third", seen[2], 0);
`endif
    end

    // Asynchronous reset 3 ms into a dah
    scen_start(5);
    set_paddles(1'b0, 1'b1);
    wait_ms(3);
    check("pre_rst_key", key_out, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_key_async", key_out, 0);
    check("rst_busy_async", busy, 0);
    set_paddles(1'b0, 1'b0);
    repeat (4) tick_cycle();
    rst = 1'b0;
    seen.delete();
    wait_ms(20);
    check("s5_stays_idle", seen.size(), 0);
    check("s5_busy", busy, 0);

    // dot_ms = 0 acts as 1 ms
    scen_start(0);
    set_paddles(1'b1, 1'b0);
    repeat (3) tick_cycle();
    set_paddles(1'b0, 1'b0);
    wait_ms(10);
    check("s6_count", seen.size(), 1);
    if (dur_q.size() > 0) check("s6_len", dur_q[0] <= T + 1, 1);

    // Dot length change mid-element applies from the next element
    scen_start(5);
    set_paddles(1'b1, 1'b0);
    wait_ms(2);
    dot_ms = 8'd10;
    wait_ms(12);
    set_paddles(1'b0, 1'b0);
    wait_ms(40);
    check("s7_count", seen.size(), 2);
    if (dur_q.size() == 2) begin
      check("s7_first_5ms", dur_q[0] <= 5 * T + 1, 1);
      check("s7_second_10ms", dur_q[1] >= 9 * T + 2, 1);
    end

    // Random paddle traffic
    for (int s = 0; s < 40; s++) begin
      set_paddles(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) dot_ms = 8'($urandom_range(0, 6));
      repeat ($urandom_range(1, 8) * T + $urandom_range(0, T - 1)) tick_cycle();
    end
    set_paddles(1'b0, 1'b0);
    wait_ms(60);
    check("final_busy", busy, 0);
    check("exp_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
